// File: rtl/divider_bank.sv
// Multi-channel programmable clock divider with per-channel toggle/pulse modes and
// boundary-aligned shadow reconfiguration. Optional strobe logic: DIVIDER_STROBE_EN.
module divider_bank #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 32,
    parameter int DEFAULT_HALF = 5,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                pulse_clock,
    input  logic                external_reset_n,
    input  logic                sync_clear,
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_channel,
    input  logic [WIDTH-1:0]    cfg_half,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] divided_clock,
    output logic [CHANNELS-1:0] period_strobe
);

    logic [CHANNELS-1:0] pend_vec;

    // Channels outside the bank are always ready so their requests drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        if (32'(cfg_channel) < CHANNELS) begin
            cfg_ready = !pend_vec[cfg_channel];
        end
    end

    assign cfg_pending = pend_vec;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] half_q, half_d;
            logic             mode_q, mode_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic             out_q, out_d;
            logic [WIDTH-1:0] sh_half_q, sh_half_d;
            logic             sh_mode_q, sh_mode_d;
            logic             pend_q, pend_d;
            logic             strobe_d;
            logic             accept, run, term, boundary, apply;

            assign accept   = cfg_valid && cfg_ready && (32'(cfg_channel) == gi);
            assign run      = enable[gi] && (half_q != '0);
            assign term     = (half_q != '0) && (cnt_q == half_q - WIDTH'(1));
            // Toggle mode only hands over on the falling edge so the high phase is never cut.
            assign boundary = sync_clear || !run || (term && (mode_q || out_q));
            // An accept can only land while pend_q is clear, so a same-cycle boundary is skipped.
            assign apply    = pend_q && boundary;

            always_comb begin
                half_d    = half_q;
                mode_d    = mode_q;
                cnt_d     = cnt_q;
                out_d     = out_q;
                sh_half_d = sh_half_q;
                sh_mode_d = sh_mode_q;
                pend_d    = pend_q;
                strobe_d  = 1'b0;

                if (accept) begin
                    sh_half_d = cfg_half;
                    sh_mode_d = cfg_mode;
                    pend_d    = 1'b1;
                end

                if (sync_clear || apply || !run) begin
                    cnt_d = '0;
                    out_d = 1'b0;
                    if (apply) begin
                        half_d = sh_half_q;
                        mode_d = sh_mode_q;
                        pend_d = 1'b0;
                    end
                end else if (term) begin
                    cnt_d    = '0;
                    out_d    = mode_q ? 1'b1 : !out_q;
                    strobe_d = mode_q ? 1'b1 : !out_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    out_d = mode_q ? 1'b0 : out_q;
                end
            end

            always_ff @(posedge pulse_clock or negedge external_reset_n) begin
                if (!external_reset_n) begin
                    half_q    <= WIDTH'(DEFAULT_HALF);
                    mode_q    <= 1'b0;
                    cnt_q     <= '0;
                    out_q     <= 1'b0;
                    sh_half_q <= WIDTH'(DEFAULT_HALF);
                    sh_mode_q <= 1'b0;
                    pend_q    <= 1'b0;
                end else begin
                    half_q    <= half_d;
                    mode_q    <= mode_d;
                    cnt_q     <= cnt_d;
                    out_q     <= out_d;
                    sh_half_q <= sh_half_d;
                    sh_mode_q <= sh_mode_d;
                    pend_q    <= pend_d;
                end
            end

`ifdef DIVIDER_STROBE_EN
            logic strobe_q;
            always_ff @(posedge pulse_clock or negedge external_reset_n) begin
                if (!external_reset_n) begin
                    strobe_q <= 1'b0;
                end else begin
                    strobe_q <= strobe_d;
                end
            end
            assign period_strobe[gi] = strobe_q;
`else
            logic unused_strobe;
            assign unused_strobe     = strobe_d;
            assign period_strobe[gi] = 1'b0;
`endif

            assign divided_clock[gi] = out_q;
            assign pend_vec[gi]      = pend_q;
        end
    endgenerate

endmodule
